// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle arithmetic/logic ops
// and iterative shift-add multiply / restoring divide.
module seq_alu #(
  parameter int BW = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic [3:0]    sel,
  output logic          ready,
  output logic          done,
  output logic [BW-1:0] dout,
  output logic [BW-1:0] dout_hi,
  output logic          V,
  output logic          C,
  output logic          Z,
  output logic          DZ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   opa;
  logic [BW-1:0]   opb;
  logic [2*BW-1:0] prod;
  logic [BW-1:0]   quo;
  logic [BW-1:0]   rem;
  logic            rem_op;

  logic [BW-1:0]   y;
  logic            cin;
  logic [BW:0]     sum;
  logic [BW-1:0]   sc_res;
  logic            sc_v;
  logic            sc_c;
  logic            sc_dz;
  logic            is_mul;
  logic            is_div;

  logic [BW:0]     madd;
  logic [2*BW-1:0] prod_nx;
  logic [BW:0]     shl;
  logic [BW:0]     diff;
  logic            ge;
  logic [BW-1:0]   rem_nx;
  logic [BW-1:0]   quo_nx;
  logic [BW-1:0]   div_res;
  logic            last;

  // Single-cycle datapath: adder operand select, logic ops, divide-by-zero
  always_comb begin
    y      = '0;
    cin    = sel[0];
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    sc_dz  = 1'b0;
    unique case (sel[2:1])
      2'b00: y = '0;
      2'b01: y = B;
      2'b10: y = ~B;
      2'b11: y = '1;
    endcase
    sum = {1'b0, A} + {1'b0, y} + {{BW{1'b0}}, cin};
    if (!sel[3]) begin
      sc_res = sum[BW-1:0];
      sc_c   = sum[BW];
      sc_v   = (A[BW-1] == y[BW-1]) && (sum[BW-1] != A[BW-1]);
    end else begin
      unique case (sel[2:0])
        3'b000: sc_res = A & B;
        3'b010: sc_res = A | B;
        3'b100: sc_res = A ^ B;
        3'b110,
        3'b111: sc_res = ~A;
        3'b011: begin
          sc_res = '1;
          sc_dz  = 1'b1;
        end
        3'b101: begin
          sc_res = A;
          sc_dz  = 1'b1;
        end
        default: sc_res = '0;
      endcase
    end
  end

  // Opcode classification for the idle dispatcher
  always_comb begin
    is_mul = (sel == 4'b1001);
    is_div = (sel == 4'b1011) || (sel == 4'b1101);
  end

  // One multiply step and one restoring-divide step per cycle
  always_comb begin
    madd    = {1'b0, prod[2*BW-1:BW]}
            + (prod[0] ? {1'b0, opa} : {(BW+1){1'b0}});
    prod_nx = {madd, prod[BW-1:1]};
    shl     = {rem, quo[BW-1]};
    diff    = shl - {1'b0, opb};
    ge      = !diff[BW];
    rem_nx  = ge ? diff[BW-1:0] : shl[BW-1:0];
    quo_nx  = {quo[BW-2:0], ge};
    div_res = rem_op ? rem_nx : quo_nx;
    last    = (cnt == CW'(BW-1));
  end

  // Control FSM with registered results and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      rem_op  <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      dout    <= '0;
      dout_hi <= '0;
      V       <= 1'b0;
      C       <= 1'b0;
      Z       <= 1'b0;
      DZ      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (is_mul) begin
              opa   <= A;
              prod  <= {{BW{1'b0}}, B};
              cnt   <= '0;
              ready <= 1'b0;
              state <= S_MUL;
            end else if (is_div && (B != '0)) begin
              opb    <= B;
              quo    <= A;
              rem    <= '0;
              rem_op <= sel[2];
              cnt    <= '0;
              ready  <= 1'b0;
              state  <= S_DIV;
            end else begin
              dout    <= sc_res;
              dout_hi <= '0;
              V       <= sc_v;
              C       <= sc_c;
              Z       <= (sc_res == '0);
              DZ      <= sc_dz;
              done    <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod <= prod_nx;
          if (last) begin
            cnt     <= '0;
            dout    <= prod_nx[BW-1:0];
            dout_hi <= prod_nx[2*BW-1:BW];
            V       <= (prod_nx[2*BW-1:BW] != '0);
            C       <= 1'b0;
            Z       <= (prod_nx[BW-1:0] == '0);
            DZ      <= 1'b0;
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          if (last) begin
            cnt     <= '0;
            dout    <= div_res;
            dout_hi <= '0;
            V       <= 1'b0;
            C       <= 1'b0;
            Z       <= (div_res == '0);
            DZ      <= 1'b0;
            done    <= 1'b1;
            ready   <= 1'b1;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu at BW=8 and BW=16
// against an arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st8, rdy8, dn8, v8, c8, z8, dz8;
  logic [7:0] a8, b8, do8, hi8;
  logic [3:0] sel8;

  logic        st16, rdy16, dn16, v16, c16, z16, dz16;
  logic [15:0] a16, b16, do16, hi16;
  logic [3:0]  sel16;

  int errs = 0;
  int checks = 0;

  seq_alu #(.BW(8), .CW(4)) u8 (
    .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .sel(sel8),
    .ready(rdy8), .done(dn8), .dout(do8), .dout_hi(hi8),
    .V(v8), .C(c8), .Z(z8), .DZ(dz8)
  );

  seq_alu #(.BW(16), .CW(5)) u16 (
    .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16), .sel(sel16),
    .ready(rdy16), .done(dn16), .dout(do16), .dout_hi(hi16),
    .V(v16), .C(c16), .Z(z16), .DZ(dz16)
  );

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        v, c, z, dz;
    int          lat;
  } exp_t;

  // Reference: the opcode map evaluated with plain integer arithmetic
  function automatic exp_t ref_alu(int w, logic [3:0] s,
                                   logic [63:0] a, logic [63:0] b);
    exp_t e;
    logic [63:0] m, y, u;
    longint sa, sy, ss, lim;
    int cin;
    e = '{default: 0};
    m = (64'd1 << w) - 64'd1;
    lim = longint'(1) << (w - 1);
    if (!s[3]) begin
      cin = int'(s[0]);
      case (s[2:1])
        2'd0: y = 64'd0;
        2'd1: y = b;
        2'd2: y = ~b & m;
        default: y = m;
      endcase
      u = a + y + 64'(cin);
      e.lo = u & m;
      e.c = u[w];
      sa = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
      sy = (longint'(y) >= lim) ? longint'(y) - 2 * lim : longint'(y);
      ss = sa + sy + longint'(cin);
      e.v = (ss >= lim) || (ss < -lim);
    end else begin
      case (s[2:0])
        3'd0: e.lo = a & b;
        3'd2: e.lo = a | b;
        3'd4: e.lo = a ^ b;
        3'd6, 3'd7: e.lo = ~a & m;
        3'd1: begin
          u = a * b;
          e.lo = u & m;
          e.hi = u >> w;
          e.v = (e.hi != 0);
          e.lat = w;
        end
        3'd3: begin
          if (b == 0) begin e.lo = m; e.dz = 1'b1; end
          else begin e.lo = a / b; e.lat = w; end
        end
        default: begin
          if (b == 0) begin e.lo = a; e.dz = 1'b1; end
          else begin e.lo = a % b; e.lat = w; end
        end
      endcase
    end
    e.z = (e.lo == 0);
    return e;
  endfunction

  // Issue one op on the 8-bit unit; lat = edges after accept until done
  task automatic go8(input logic [3:0] s, input logic [7:0] a,
                     input logic [7:0] b, output int lat);
    @(negedge clk);
    sel8 = s; a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 4'($urandom);
    lat = 0;
    @(negedge clk);
    while (!dn8 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic go16(input logic [3:0] s, input logic [15:0] a,
                      input logic [15:0] b, output int lat);
    @(negedge clk);
    sel16 = s; a16 = a; b16 = b; st16 = 1'b1;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    @(negedge clk);
    while (!dn16 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    st8 = 0; a8 = 0; b8 = 0; sel8 = 0;
    st16 = 0; a16 = 0; b16 = 0; sel16 = 0;
    #12;
    checks++;
    if ({rdy8, dn8, do8, hi8, v8, c8, z8, dz8} !== {2'b10, 20'h0}) begin
      errs++;
      $display("FAIL reset8 got rdy=%b dn=%b do=%h hi=%h vczd=%b%b%b%b",
               rdy8, dn8, do8, hi8, v8, c8, z8, dz8);
    end
    checks++;
    if ({rdy16, dn16, do16, hi16} !== {2'b10, 32'h0}) begin
      errs++;
      $display("FAIL reset16 got rdy=%b dn=%b do=%h hi=%h",
               rdy16, dn16, do16, hi16);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    go8(4'b0010, 8'h7F, 8'h01, lat);
    checks++;
    if ({lat, rdy8, do8, v8, c8, z8} !== {32'd0, 1'b1, 8'h80, 3'b100}) begin
      errs++;
      $display("FAIL add lat=%0d rdy=%b do=%h vcz=%b%b%b need 0 1 80 100",
               lat, rdy8, do8, v8, c8, z8);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sel8 = 4'b0101; a8 = 8'h05; b8 = 8'h05; st8 = 1'b1;
    @(negedge clk);
    checks++;
    if ({dn8, rdy8, do8, z8, c8, v8} !== {2'b11, 8'h00, 3'b110}) begin
      errs++;
      $display("FAIL b2b_first dn=%b rdy=%b do=%h zcv=%b%b%b need 1 1 00 110",
               dn8, rdy8, do8, z8, c8, v8);
    end
    sel8 = 4'b1100; a8 = 8'hF0; b8 = 8'hFF;
    @(negedge clk);
    st8 = 1'b0;
    checks++;
    if ({dn8, do8, v8, c8, z8} !== {1'b1, 8'h0F, 3'b000}) begin
      errs++;
      $display("FAIL b2b_second dn=%b do=%h vcz=%b%b%b need 1 0f 000",
               dn8, do8, v8, c8, z8);
    end
    @(negedge clk);
    checks++;
    if ({dn8, do8} !== {1'b0, 8'h0F}) begin
      errs++;
      $display("FAIL b2b_hold dn=%b do=%h need 0 0f", dn8, do8);
    end
  endtask

  task automatic test_mul;
    int bad;
    bad = 0;
    @(negedge clk);
    sel8 = 4'b1001; a8 = 8'hFF; b8 = 8'hFF; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rdy8 !== 1'b0 || dn8 !== 1'b0) bad++;
      if (k == 3) begin
        st8 = 1'b1; sel8 = 4'b0010; a8 = 8'h12; b8 = 8'h34;
      end else begin
        st8 = 1'b0;
      end
      @(negedge clk);
    end
    st8 = 1'b0;
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL mul_busy bad_cycles=%0d need 0", bad);
    end
    checks++;
    if ({dn8, rdy8, hi8, do8, v8} !== {2'b11, 16'hFE01, 1'b1}) begin
      errs++;
      $display("FAIL mul_result dn=%b rdy=%b prod=%h%h v=%b need 1 1 fe01 1",
               dn8, rdy8, hi8, do8, v8);
    end
  endtask

  task automatic test_div;
    int lat;
    go8(4'b1011, 8'd200, 8'd7, lat);
    checks++;
    if ({lat, do8, hi8, dz8} !== {32'd8, 8'd28, 8'd0, 1'b0}) begin
      errs++;
      $display("FAIL divq lat=%0d do=%0d hi=%0d dz=%b need 8 28 0 0",
               lat, do8, hi8, dz8);
    end
    go8(4'b1101, 8'd200, 8'd7, lat);
    checks++;
    if ({lat, do8, dz8} !== {32'd8, 8'd4, 1'b0}) begin
      errs++;
      $display("FAIL divr lat=%0d do=%0d dz=%b need 8 4 0", lat, do8, dz8);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    go8(4'b1011, 8'h37, 8'h00, lat);
    checks++;
    if ({lat, do8, dz8, z8} !== {32'd0, 8'hFF, 2'b10}) begin
      errs++;
      $display("FAIL dz_q lat=%0d do=%h dz=%b z=%b need 0 ff 1 0",
               lat, do8, dz8, z8);
    end
    go8(4'b1101, 8'h37, 8'h00, lat);
    checks++;
    if ({lat, do8, dz8} !== {32'd0, 8'h37, 1'b1}) begin
      errs++;
      $display("FAIL dz_r lat=%0d do=%h dz=%b need 0 37 1", lat, do8, dz8);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    seen = 0;
    @(negedge clk);
    sel8 = 4'b1001; a8 = 8'h12; b8 = 8'h34; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rdy8, dn8, do8, hi8, v8, c8, z8, dz8} !== {2'b10, 20'h0}) begin
      errs++;
      $display("FAIL rst_mid rdy=%b dn=%b do=%h hi=%h vczd=%b%b%b%b",
               rdy8, dn8, do8, hi8, v8, c8, z8, dz8);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (dn8 !== 1'b0 || rdy8 !== 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errs++;
      $display("FAIL rst_abandon bad_cycles=%0d need 0", seen);
    end
    go8(4'b1001, 8'h12, 8'h34, lat);
    checks++;
    if ({lat, hi8, do8, v8} !== {32'd8, 16'h03A8, 1'b1}) begin
      errs++;
      $display("FAIL mul_after_rst lat=%0d prod=%h%h v=%b need 8 03a8 1",
               lat, hi8, do8, v8);
    end
  endtask

  task automatic test_random8;
    int lat;
    exp_t e;
    logic [3:0] s;
    logic [7:0] a, b, held;
    for (int i = 0; i < 150; i++) begin
      s = 4'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      e = ref_alu(8, s, 64'(a), 64'(b));
      go8(s, a, b, lat);
      checks++;
      if (lat != e.lat || do8 !== e.lo[7:0] || hi8 !== e.hi[7:0] ||
          {v8, c8, z8, dz8} !== {e.v, e.c, e.z, e.dz}) begin
        errs++;
        $display("FAIL rand8 sel=%b a=%h b=%h got lat=%0d %h_%h vczd=%b%b%b%b need lat=%0d %h_%h vczd=%b%b%b%b",
                 s, a, b, lat, hi8, do8, v8, c8, z8, dz8,
                 e.lat, e.hi[7:0], e.lo[7:0], e.v, e.c, e.z, e.dz);
      end
      held = do8;
      @(negedge clk);
      checks++;
      if (dn8 !== 1'b0 || do8 !== held) begin
        errs++;
        $display("FAIL rand8_hold dn=%b do=%h need 0 %h", dn8, do8, held);
      end
    end
  endtask

  task automatic test_bw16;
    int lat;
    exp_t e;
    logic [3:0] s;
    logic [15:0] a, b;
    go16(4'b1001, 16'hFFFF, 16'h0002, lat);
    checks++;
    if ({lat, hi16, do16, v16} !== {32'd16, 32'h0001_FFFE, 1'b1}) begin
      errs++;
      $display("FAIL mul16 lat=%0d prod=%h_%h v=%b need 16 0001_fffe 1",
               lat, hi16, do16, v16);
    end
    for (int i = 0; i < 30; i++) begin
      s = 4'($urandom);
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      e = ref_alu(16, s, 64'(a), 64'(b));
      go16(s, a, b, lat);
      checks++;
      if (lat != e.lat || do16 !== e.lo[15:0] || hi16 !== e.hi[15:0] ||
          {v16, c16, z16, dz16} !== {e.v, e.c, e.z, e.dz}) begin
        errs++;
        $display("FAIL rand16 sel=%b a=%h b=%h got lat=%0d %h_%h vczd=%b%b%b%b need lat=%0d %h_%h",
                 s, a, b, lat, hi16, do16, v16, c16, z16, dz16,
                 e.lat, e.hi[15:0], e.lo[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_div_zero();
    test_reset_mid();
    test_random8();
    test_bw16();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU with one clock.
- Keeps the team's 4-bit sel opcode map:
  - single-cycle arithmetic and logic ops.
  - iterative multi-cycle unsigned multiply (full 2*BW product) and divide (quotient or remainder).
- Operands are captured on a start/ready handshake; completion is signalled by a done pulse.
- Sits between the register file and writeback in the 16-bit CPU datapath; BW defaults to 16.

Parameters:
- BW, 16, operand/result width (>=4).
- CW, 5, iteration counter width; must satisfy 2^CW > BW.

Ports:
- clk    in   1     rising-edge clock
- rst    in   1     asynchronous, active-high reset
- start  in   1     request; accepted only when ready=1
- A      in   BW    operand A, sampled on the accepting edge
- B      in   BW    operand B, sampled on the accepting edge
- sel    in   4     opcode, sampled on the accepting edge
- ready  out  1     idle, can accept start
- done   out  1     one-cycle pulse: result registers updated
- dout   out  BW    result (low half of product for MUL)
- dout_hi out BW    high half of product; 0 for all other ops
- V      out  1     overflow flag
- C      out  1     carry flag
- Z      out  1     dout==0
- DZ     out  1     divide-by-zero flag

Behaviour:
- Reset (async, any state): state=IDLE; ready=1; done=0; dout, dout_hi, V, C, Z, DZ all 0. Any in-flight MUL/DIV is abandoned.
- Opcode map:
  - sel[3]=0, arithmetic: result = A + Y + cin, BW-bit add.
  - sel[2:0] / Y / cin: 000 / 0 / 0 (A); 001 / 0 / 1 (A+1); 010 / B / 0 (A+B); 011 / B / 1 (A+B+1); 100 / ~B / 0 (A-B-1); 101 / ~B / 1 (A-B); 110 / all-ones / 0 (A-1); 111 / all-ones / 1 (A).
  - Arithmetic flags: C = carry-out of bit BW-1 (1 = no borrow on subtract); V = signed overflow of A + Y + cin; dout_hi=0; DZ=0.
  - Logic ops: 1000 A&B; 1010 A|B; 1100 A^B; 1110 and 1111 ~A. V=C=0.
  - 1001 MUL: unsigned A*B; {dout_hi,dout} = 2*BW product. V = (dout_hi!=0); C=0.
  - 1011 DIVQ: dout = A/B. 1101 DIVR: dout = A%B. Unsigned; V=C=0; dout_hi=0.
  - Division by zero (B=0): DIVQ gives all-ones; DIVR gives A; DZ=1. Otherwise DZ=0.
  - Z is always computed from the dout written with that op.
- FSM states: IDLE, MUL, DIV.
- IDLE:
  - ready=1.
  - start with a single-cycle op: result and flags registered on the accepting edge; done=1 for the following cycle; remains IDLE, so back-to-back starts are allowed every cycle.
  - start with 1001: latch A, B; clear accumulator; cnt=0; go to MUL.
  - start with 1011/1101: latch A, B, sel; cnt=0; go to DIV.
  - start with B=0 and a divide op: completes as a single-cycle op (DZ path); no DIV state.
- MUL: one shift-add step per edge. On the edge where cnt reaches BW-1: write outputs, done=1, return to IDLE.
- DIV: one restoring-divide step per edge, same termination rule as MUL.
- Latency, with the accepting edge = edge 0:
  - single-cycle ops: results and done valid after edge 0.
  - MUL/DIV: ready=0 after edges 0..BW-1; results, done=1 and ready=1 after edge BW.
- start while ready=0: ignored, no side effects. Input changes after the accepting edge do not affect the result.
- Outputs hold their values until the next completion or reset. done is 0 except in the single cycle after a completion.
- Counter never exceeds BW-1; no wrap.

Test Plan (BW=8 unless noted):
- Reset, then sel=0010, A=0x7F, B=0x01, start -> next cycle done=1, dout=0x80, V=1, C=0, Z=0, ready stays 1.
- sel=0101, A=0x05, B=0x05, then immediately sel=1100, A=0xF0, B=0xFF on the following cycle -> first result dout=0x00, Z=1, C=1, V=0; second result dout=0x0F, V=C=0; two consecutive done pulses.
- sel=1001, A=0xFF, B=0xFF -> ready=0 for 8 cycles; a start at cycle 3 with different operands is ignored; at cycle 8 done=1, dout_hi=0xFE, dout=0x01, V=1.
- sel=1011, A=200, B=7 -> dout=28 after 8 cycles. Then sel=1101, same operands -> dout=4, DZ=0.
- sel=1011, A=0x37, B=0 -> next cycle dout=0xFF, DZ=1. Then sel=1101, A=0x37, B=0 -> dout=0x37, DZ=1.
- Start MUL (0x12*0x34); assert rst at cycle 4 -> all outputs 0, ready=1, done never pulses. Then a new MUL 0x12*0x34 -> {dout_hi,dout}=0x03A8. Repeat the MUL with BW=16: A=0xFFFF, B=0x0002 -> done at cycle 16, {dout_hi,dout}=0x0001_FFFE.
